// File: rtl/exec_unit.sv
// rtl/exec_unit.sv - integer execute unit: single-cycle ALU plus iterative multiply/divide
module exec_unit #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            io_flush,
    input  logic            io_in_valid,
    output logic            io_in_ready,
    input  logic [3:0]      io_cmd,
    input  logic [XLEN-1:0] io_rs1,
    input  logic [XLEN-1:0] io_rs2,
    input  logic [XLEN-1:0] io_imm,
    input  logic            io_use_imm,
    output logic [XLEN-1:0] io_out,
    output logic            io_out_valid,
    output logic            io_err,
    output logic            io_busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic            accept;
    logic            is_mul;
    logic            is_div;
    logic [XLEN-1:0] op_b;
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] alu_res;
    logic            alu_illegal;

    // acc_hi/acc_lo hold product halves for MUL, remainder/quotient for DIV
    logic [XLEN-1:0] acc_hi;
    logic [XLEN-1:0] acc_lo;
    logic [XLEN-1:0] opnd;
    logic [SHW-1:0]  cnt;
    logic            sel_hi;
    logic            last;

    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   div_shift;
    logic [XLEN:0]   div_diff;
    logic            div_ge;
    logic [XLEN-1:0] it_hi;
    logic [XLEN-1:0] it_lo;

    assign op_b   = io_use_imm ? io_imm : io_rs2;
    assign shamt  = op_b[SHW-1:0];
    assign is_mul = (io_cmd == 4'd10) || (io_cmd == 4'd11);
    assign is_div = (io_cmd == 4'd12) || (io_cmd == 4'd13);
    assign accept = io_in_valid && io_in_ready && !io_flush && !reset;
    assign last   = (cnt == SHW'(XLEN - 1));

    always_comb begin
        alu_res     = '0;
        alu_illegal = 1'b0;
        case (io_cmd)
            4'd0:    alu_res = io_rs1 + op_b;
            4'd1:    alu_res = io_rs1 - op_b;
            4'd2:    alu_res = io_rs1 & op_b;
            4'd3:    alu_res = io_rs1 | op_b;
            4'd4:    alu_res = io_rs1 ^ op_b;
            4'd5:    alu_res = io_rs1 << shamt;
            4'd6:    alu_res = io_rs1 >> shamt;
            4'd7:    alu_res = $unsigned($signed(io_rs1) >>> shamt);
            4'd8:    alu_res = {{(XLEN-1){1'b0}}, ($signed(io_rs1) < $signed(op_b))};
            4'd9:    alu_res = {{(XLEN-1){1'b0}}, (io_rs1 < op_b)};
            4'd10,
            4'd11,
            4'd12,
            4'd13:   alu_res = '0;
            default: alu_illegal = 1'b1;
        endcase
    end

    // One shift-add step: conditionally add multiplicand into the high half, then shift right
    assign mul_sum = acc_lo[0] ? ({1'b0, acc_hi} + {1'b0, opnd}) : {1'b0, acc_hi};

    // One restoring step; a zero divisor naturally yields all-ones quotient and remainder = dividend
    assign div_shift = {acc_hi, acc_lo[XLEN-1]};
    assign div_diff  = div_shift - {1'b0, opnd};
    assign div_ge    = (div_shift >= {1'b0, opnd});

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept && is_mul) begin
                    state_nxt = S_MUL;
                end else if (accept && is_div) begin
                    state_nxt = S_DIV;
                end
            end
            S_MUL,
            S_DIV: begin
                if (io_flush || last) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        io_in_ready = (state == S_IDLE);
        io_busy     = (state != S_IDLE);
        it_hi       = acc_hi;
        it_lo       = acc_lo;
        if (state == S_MUL) begin
            it_hi = mul_sum[XLEN:1];
            it_lo = {mul_sum[0], acc_lo[XLEN-1:1]};
        end else if (state == S_DIV) begin
            it_hi = div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
            it_lo = {acc_lo[XLEN-2:0], div_ge};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            io_out       <= '0;
            io_out_valid <= 1'b0;
            io_err       <= 1'b0;
            acc_hi       <= '0;
            acc_lo       <= '0;
            opnd         <= '0;
            cnt          <= '0;
            sel_hi       <= 1'b0;
        end else begin
            io_out_valid <= 1'b0;
            io_err       <= 1'b0;
            if (accept) begin
                if (is_mul) begin
                    acc_hi <= '0;
                    acc_lo <= op_b;
                    opnd   <= io_rs1;
                    cnt    <= '0;
                    sel_hi <= (io_cmd == 4'd11);
                end else if (is_div) begin
                    acc_hi <= '0;
                    acc_lo <= io_rs1;
                    opnd   <= op_b;
                    cnt    <= '0;
                    sel_hi <= (io_cmd == 4'd13);
                end else begin
                    io_out       <= alu_res;
                    io_out_valid <= 1'b1;
                    io_err       <= alu_illegal;
                end
            end else if (io_busy && !io_flush) begin
                acc_hi <= it_hi;
                acc_lo <= it_lo;
                cnt    <= cnt + SHW'(1);
                if (last) begin
                    io_out       <= sel_hi ? it_hi : it_lo;
                    io_out_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_exec_unit.sv
// tb/tb_exec_unit.sv - randomized self-checking bench for exec_unit against an arithmetic model
module tb_exec_unit;

    localparam int XLEN = 32;

    logic            clock = 1'b0;
    logic            reset;
    logic            io_flush;
    logic            io_in_valid;
    logic            io_in_ready;
    logic [3:0]      io_cmd;
    logic [XLEN-1:0] io_rs1;
    logic [XLEN-1:0] io_rs2;
    logic [XLEN-1:0] io_imm;
    logic            io_use_imm;
    logic [XLEN-1:0] io_out;
    logic            io_out_valid;
    logic            io_err;
    logic            io_busy;

    int checks = 0;
    int errors = 0;
    logic [31:0] model_out = '0;

    exec_unit #(.XLEN(XLEN)) dut (
        .clock        (clock),
        .reset        (reset),
        .io_flush     (io_flush),
        .io_in_valid  (io_in_valid),
        .io_in_ready  (io_in_ready),
        .io_cmd       (io_cmd),
        .io_rs1       (io_rs1),
        .io_rs2       (io_rs2),
        .io_imm       (io_imm),
        .io_use_imm   (io_use_imm),
        .io_out       (io_out),
        .io_out_valid (io_out_valid),
        .io_err       (io_err),
        .io_busy      (io_busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Returns {err, result} computed from the opcode definitions with plain wide arithmetic
    function automatic logic [32:0] model(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b);
        longint unsigned ua, ub, prod;
        int unsigned sh;
        logic [31:0] r;
        ua   = a;
        ub   = b;
        prod = ua * ub;
        sh   = b % 32;
        r    = '0;
        case (cmd)
            4'd0:  r = 32'((ua + ub) % 64'h1_0000_0000);
            4'd1:  r = 32'((ua + 64'h1_0000_0000 - ub) % 64'h1_0000_0000);
            4'd2:  r = a & b;
            4'd3:  r = a | b;
            4'd4:  r = a ^ b;
            4'd5:  r = 32'((ua * (64'd1 << sh)) % 64'h1_0000_0000);
            4'd6:  r = 32'(ua / (64'd1 << sh));
            4'd7:  r = 32'(ua / (64'd1 << sh)) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
            4'd8:  r = ((a[31] && !b[31]) || ((a[31] == b[31]) && (a < b))) ? 32'd1 : 32'd0;
            4'd9:  r = (ua < ub) ? 32'd1 : 32'd0;
            4'd10: r = prod[31:0];
            4'd11: r = prod[63:32];
            4'd12: r = (b == 0) ? 32'hFFFF_FFFF : 32'(ua / ub);
            4'd13: r = (b == 0) ? a : 32'(ua % ub);
            default: return {1'b1, 32'd0};
        endcase
        return {1'b0, r};
    endfunction

    function automatic logic [31:0] rnd_op();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    task automatic quiet_inputs();
        io_in_valid = 1'b0;
        io_flush    = 1'b0;
        io_cmd      = 4'd0;
        io_rs1      = '0;
        io_rs2      = '0;
        io_imm      = '0;
        io_use_imm  = 1'b0;
    endtask

    task automatic run_cmd(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] rs2,
                           input logic [31:0] imm, input logic use_imm);
        logic [32:0] exp;
        logic [31:0] b;
        int lat;
        int exp_lat;
        b       = use_imm ? imm : rs2;
        exp     = model(cmd, a, b);
        exp_lat = (cmd >= 4'd10 && cmd <= 4'd13) ? XLEN + 1 : 1;
        check("ready_before", io_in_ready, 1);
        io_in_valid = 1'b1;
        io_cmd      = cmd;
        io_rs1      = a;
        io_rs2      = rs2;
        io_imm      = imm;
        io_use_imm  = use_imm;
        step();
        io_in_valid = 1'b0;
        lat = 1;
        while (!io_out_valid && lat < 40) begin
            check($sformatf("ready_busy_cmd%0d", cmd), {io_in_ready, io_busy}, 2'b01);
            io_in_valid = 1'($urandom_range(0, 1));
            io_cmd      = 4'($urandom);
            io_rs1      = $urandom;
            io_rs2      = $urandom;
            step();
            lat++;
        end
        io_in_valid = 1'b0;
        check($sformatf("latency_cmd%0d", cmd), lat, exp_lat);
        check($sformatf("result_cmd%0d_a%h_b%h", cmd, a, b), io_out, exp[31:0]);
        check($sformatf("err_cmd%0d", cmd), io_err, exp[32]);
        check("ready_at_strobe", io_in_ready, 1);
        model_out = exp[31:0];
        step();
        check("strobe_one_cycle", {io_out_valid, io_err}, 2'b00);
        check("out_hold", io_out, model_out);
    endtask

    // Start a DIVU/MUL and abort it with flush or reset in the given cycle after accept
    task automatic abort_cmd(input logic [3:0] cmd, input int at_cycle, input logic use_reset);
        int seen;
        io_in_valid = 1'b1;
        io_cmd      = cmd;
        io_rs1      = 32'd100;
        io_rs2      = 32'd7;
        io_use_imm  = 1'b0;
        step();
        io_in_valid = 1'b0;
        seen = 0;
        for (int c = 1; c < at_cycle; c++) begin
            if (io_out_valid) seen++;
            step();
        end
        if (use_reset) reset = 1'b1;
        else io_flush = 1'b1;
        step();
        reset    = 1'b0;
        io_flush = 1'b0;
        if (use_reset) model_out = '0;
        check("abort_ready", {io_in_ready, io_busy}, 2'b10);
        check("abort_out", io_out, model_out);
        for (int c = 0; c < 40; c++) begin
            if (io_out_valid || io_err) seen++;
            step();
        end
        check("abort_no_strobe", seen, 0);
    endtask

    initial begin
        logic [31:0] ba [10];
        logic [31:0] bb [10];
        quiet_inputs();
        reset       = 1'b1;
        io_in_valid = 1'b1;
        io_flush    = 1'b1;
        step();
        step();
        reset = 1'b0;
        quiet_inputs();
        check("reset_out", io_out, 0);
        check("reset_flags", {io_out_valid, io_err, io_busy, io_in_ready}, 4'b0001);

        run_cmd(4'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);
        run_cmd(4'd1, 32'd0, 32'd1, 32'd0, 1'b0);
        run_cmd(4'd5, 32'd3, 32'd0, 32'd5, 1'b1);
        run_cmd(4'd7, 32'h8000_0000, 32'h24, 32'd0, 1'b0);
        run_cmd(4'd8, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);
        run_cmd(4'd9, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);
        run_cmd(4'd10, 32'h10000, 32'h10000, 32'd0, 1'b0);
        run_cmd(4'd11, 32'h10000, 32'h10000, 32'd0, 1'b0);
        run_cmd(4'd12, 32'd100, 32'd7, 32'd0, 1'b0);
        run_cmd(4'd13, 32'd100, 32'd7, 32'd0, 1'b0);
        run_cmd(4'd12, 32'd5, 32'd0, 32'd0, 1'b0);
        run_cmd(4'd13, 32'd5, 32'd0, 32'd0, 1'b0);
        run_cmd(4'd14, 32'd9, 32'd9, 32'd0, 1'b0);
        run_cmd(4'd15, 32'd1, 32'd2, 32'd0, 1'b0);

        for (int n = 0; n < 150; n++) begin
            run_cmd(4'($urandom), rnd_op(), rnd_op(), rnd_op(), 1'($urandom_range(0, 1)));
        end

        for (int i = 0; i < 10; i++) begin
            ba[i] = $urandom;
            bb[i] = $urandom;
            check("b2b_ready", io_in_ready, 1);
            io_in_valid = 1'b1;
            io_cmd      = 4'd0;
            io_rs1      = ba[i];
            io_rs2      = bb[i];
            io_use_imm  = 1'b0;
            step();
            check("b2b_valid", io_out_valid, 1);
            check("b2b_sum", io_out, model(4'd0, ba[i], bb[i]));
        end
        io_in_valid = 1'b0;
        model_out = model(4'd0, ba[9], bb[9]);
        step();
        check("b2b_end", io_out_valid, 0);

        io_in_valid = 1'b1;
        io_flush    = 1'b1;
        io_cmd      = 4'd0;
        io_rs1      = 32'd1;
        io_rs2      = 32'd1;
        step();
        quiet_inputs();
        check("flush_idle_block", {io_out_valid, io_busy}, 2'b00);
        check("flush_idle_out", io_out, model_out);

        abort_cmd(4'd12, 10, 1'b0);
        abort_cmd(4'd10, 32, 1'b0);
        run_cmd(4'd3, 32'h1234_0000, 32'h0000_5678, 32'd0, 1'b0);
        abort_cmd(4'd12, 10, 1'b1);
        run_cmd(4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/exec_unit.md
EXEC_UNIT -- requirements
Module: exec_unit

Interface
REQ-001 Parameter XLEN, default 32, operand/result width; SHALL be a power of two, 8 to 64.
REQ-002 Parameter SHW, default log2(XLEN), shift-amount width taken from operand LSBs.
REQ-003 clock  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 io_flush  input  1  synchronous abort of any in-flight operation.
REQ-006 io_in_valid  input  1  command present.
REQ-007 io_in_ready  output  1  unit can accept a command this cycle.
REQ-008 io_cmd  input  4  operation code (REQ-012).
REQ-009 io_rs1, io_rs2, io_imm  input  XLEN each  operand A, operand B, immediate.
REQ-010 io_use_imm  input  1  1 selects io_imm as operand B instead of io_rs2.
REQ-011 io_out  output XLEN registered result; io_out_valid output 1 one-cycle result strobe; io_err output 1 one-cycle illegal-command strobe; io_busy output 1 multi-cycle op in progress.

Function
REQ-012 Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, 10 MUL (low XLEN), 11 MULHU (high XLEN, unsigned), 12 DIVU, 13 REMU; 14-15 illegal.
REQ-013 Accept SHALL occur only when io_in_valid && io_in_ready && !io_flush && !reset; operands and cmd SHALL be captured at accept.
REQ-014 States: IDLE, MUL, DIV; io_in_ready = (state == IDLE); io_busy = (state != IDLE).
REQ-015 Opcodes 0-9: result in io_out with io_out_valid=1 in the cycle after accept; state stays IDLE; back-to-back accepts every cycle SHALL be supported.
REQ-016 ADD/SUB wrap modulo 2^XLEN, no carry/overflow output.
REQ-017 Shifts use operand B[SHW-1:0] only; SRA sign-fills from bit XLEN-1.
REQ-018 SLT signed, SLTU unsigned compare; result 1 or 0, zero-extended to XLEN.
REQ-019 MUL/MULHU: IDLE->MUL at accept; iterative shift-add, one bit per cycle, XLEN cycles; io_out_valid asserted XLEN+1 cycles after accept; MUL->IDLE in that same cycle.
REQ-020 DIVU/REMU: IDLE->DIV at accept; restoring division, one quotient bit per cycle; same latency as REQ-019; DIV->IDLE on completion.
REQ-021 Divide by zero: DIVU result all ones, REMU result = operand A; latency unchanged.
REQ-022 Illegal opcode: accepted, io_err=1 and io_out_valid=1 cycle after accept, io_out=0.
REQ-023 io_out SHALL hold its value between strobes; io_out_valid and io_err SHALL never be high for more than one consecutive cycle per command.
REQ-024 io_flush in MUL/DIV: next state IDLE, no io_out_valid for aborted op, io_out unchanged; io_flush in IDLE blocks accept; flush coinciding with completion cycle suppresses the strobe.
REQ-025 Command inputs SHALL be ignored while io_in_ready=0; no queuing.

Reset
REQ-026 reset SHALL override io_flush and io_in_valid.
REQ-027 In the cycle after reset is sampled high: state IDLE, io_out=0, io_out_valid=0, io_err=0, io_busy=0, io_in_ready=1; all iteration counters and partial products/remainders cleared.
REQ-028 reset asserted mid MUL/DIV SHALL abort with no result strobe.

Verification
REQ-029 XLEN=32: ADD 0xFFFFFFFF+1 -> io_out=0 one cycle later; SUB 0-1 -> 0xFFFFFFFF; io_use_imm=1, io_imm=5, rs1=3, SLL -> 0x60.
REQ-030 SRA rs1=0x80000000, rs2=0x24 (shift 4) -> 0xF8000000; SLT 0xFFFFFFFF vs 1 -> 1; SLTU same -> 0.
REQ-031 MUL 0x10000 x 0x10000 -> io_out=0 at cycle 33 after accept; MULHU same -> 1; io_in_ready=0 during cycles 1-32.
REQ-032 DIVU 100/7 -> 14, REMU -> 2, each at cycle 33; DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5.
REQ-033 Start DIVU, assert io_flush at cycle 10 -> no io_out_valid, io_in_ready=1 next cycle, io_out holds prior value; repeat with reset -> io_out=0.
REQ-034 io_cmd=14 -> io_err=1, io_out_valid=1, io_out=0 one cycle later; ten back-to-back ADDs -> ten consecutive strobes.
